xilinx_one_port_ram_pipe: RTL and testbench
===========================================

Name: xilinx_one_port_ram_pipe

Overview:
Parametrised single-port synchronous block RAM. Successor to the basic one-port RAM, adding:
- per-column (byte) write enables
- selectable write/read collision mode
- optional output pipeline register
- access-enable / data-valid handshake
- optional hardware clear sweep after reset

Sits between bus/controller logic and a BRAM primitive. Infers a single BRAM in all modes.

Parameters:
ADDR_WIDTH, 12, address bits; depth = 2**ADDR_WIDTH words
COL_WIDTH, 8, bits per write-enable column
NB_COL, 1, number of columns; DATA_WIDTH = NB_COL*COL_WIDTH
WRITE_MODE, 0, 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
OUT_REG, 0, 1 = extra output register; read latency L = 1 + OUT_REG
CLEAR_ON_RESET, 1, 1 = zero all words after reset before accepting accesses

Ports:
clk  input  1  rising-edge clock, sole clock
reset  input  1  synchronous, active-high reset
en  input  1  access request; accepted when en & ready
we  input  1  write request (qualified by en and be)
be  input  NB_COL  column write enables; be[i] covers din[i*COL_WIDTH +: COL_WIDTH]
addr  input  ADDR_WIDTH  word address
din  input  NB_COL*COL_WIDTH  write data
dout  output  NB_COL*COL_WIDTH  read data
dout_valid  output  1  dout carries the result of an accepted access
ready  output  1  block accepts accesses

Behaviour:
- Reset (sampled at posedge clk while reset=1):
  - dout=0, dout_valid=0, all pipeline stages invalidated.
  - In-flight reads are discarded and never produce dout_valid.
  - ready=0 while reset=1.
- FSM states: CLEAR, RUN.
  - CLEAR_ON_RESET=1: reset forces CLEAR with clr_cnt=0. Each cycle writes 0 to mem[clr_cnt], then clr_cnt+1. After writing address 2**ADDR_WIDTH-1, go to RUN. ready=1 from the first cycle in RUN, i.e. 2**ADDR_WIDTH cycles after reset deasserts.
  - Reset during CLEAR restarts the sweep at 0.
  - CLEAR_ON_RESET=0: reset forces RUN, and ready=1 the first cycle after reset deasserts. Memory contents are preserved across reset.
- Accepted access (en & ready in RUN), where write = we & |be:
  - Write: mem[addr] column i <= din column i for each set be[i]. Other columns are unchanged.
  - we=1 with be=0 is treated as a read.
- Requests while ready=0 are ignored: no memory change and no dout_valid.
- Read data per accepted access, presented L cycles later:
  - Read: mem[addr] before this cycle's update.
  - Write, READ_FIRST: old word.
  - Write, WRITE_FIRST: merged new word (written columns new, others old).
  - Write, NO_CHANGE: no result; dout holds its previous value and dout_valid stays 0 for that slot.
- dout_valid is asserted exactly in the cycle dout carries a result.
- dout holds its last value when dout_valid=0 and is never cleared except by reset.
- Throughput: one access per cycle, no bubbles, results in request order.
- Accesses in consecutive cycles to the same address see the earlier write (RAM ordering). No extra bypass is needed beyond the WRITE_MODE rules.
- Addresses wrap naturally; there is no out-of-range case.
- The clear counter is ADDR_WIDTH+1 bits or uses an explicit last-address compare. It must not wrap back into CLEAR.

Test Plan (ADDR_WIDTH=4, NB_COL=2, COL_WIDTH=8):
1. CLEAR_ON_RESET=1, memory preloaded with 0xFFFF, reset 2 cycles:
   - ready=0 for exactly 16 cycles after reset falls.
   - Reads of addr 0..15 then return 0x0000 with dout_valid.
2. Write addr 3 = 0xABCD (be=11), then write addr 3 = 0x1234 (be=01), then read addr 3:
   - dout=0xAB34, valid 1 cycle after the read (OUT_REG=0) or 2 cycles after (OUT_REG=1).
3. addr 5 holds 0x1111; write 0x2222 (be=11):
   - READ_FIRST: dout=0x1111, valid=1.
   - WRITE_FIRST: dout=0x2222, valid=1.
   - NO_CHANGE: dout keeps its prior value, valid=0.
   - A following read of addr 5 returns 0x2222 in all three modes.
4. Back-to-back reads of addr 0..15 (en held high, 16 cycles, distinct data):
   - 16 consecutive dout_valid pulses, in address order, no gaps, with latency L.
5. Reset at clr_cnt=7:
   - Sweep restarts; ready rises 16 cycles after the second reset falls.
   - Reset with a read in flight (OUT_REG=1): dout=0, no dout_valid.
6. en=1, we=1, be=11, addr 9, din 0xBEEF while ready=0:
   - A later read of addr 9 returns 0x0000; no dout_valid is produced for the ignored request.

Source files
------------

// File: rtl/xilinx_one_port_ram_pipe_if.sv
// xilinx_one_port_ram_pipe_if: access/response bundle between a bus controller and the pipelined one-port RAM
interface xilinx_one_port_ram_pipe_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int COL_WIDTH = 8,
  parameter int NB_COL = 1
);
  logic en;
  logic we;
  logic [NB_COL-1:0] be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NB_COL*COL_WIDTH-1:0] din;
  logic [NB_COL*COL_WIDTH-1:0] dout;
  logic dout_valid;
  logic ready;
  modport master (output en, we, be, addr, din, input dout, dout_valid, ready);
  modport slave (input en, we, be, addr, din, output dout, dout_valid, ready);
endinterface

// File: rtl/xilinx_one_port_ram_pipe.sv
// xilinx_one_port_ram_pipe: byte-enabled single-port BRAM with collision modes, optional output register and post-reset clear sweep
module xilinx_one_port_ram_pipe #(
  parameter int ADDR_WIDTH = 12,
  parameter int COL_WIDTH = 8,
  parameter int NB_COL = 1,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic reset,
  xilinx_one_port_ram_pipe_if.slave bus
);
  localparam int DW = NB_COL * COL_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {CLEAR, RUN} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q, rd_word, dout_q, dout_d, wr_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NB_COL-1:0] wr_col;
  logic clearing, acc, wr, rd_en;
  logic v1_q, v1_d, v2_q, v2_d;
  // mode register and sweep counter; reset restarts the sweep from address 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
  // sweep sequencing, access qualification and write-port steering
  always_comb begin
    clearing = state_q == CLEAR && !reset;
    bus.ready = state_q == RUN && !reset;
    acc = bus.en && bus.ready;
    wr = acc && bus.we && |bus.be;
    rd_en = acc && (!wr || WRITE_MODE != 2);
    state_d = clearing && &clr_cnt_q ? RUN : state_q;
    clr_cnt_d = clearing ? clr_cnt_q + ADDR_WIDTH'(1) : clr_cnt_q;
    wr_addr = clearing ? clr_cnt_q : bus.addr;
    wr_data = clearing ? '0 : bus.din;
    wr_col = clearing ? '1 : (wr ? bus.be : '0);
  end
  // write-first returns the merged word: written columns new, the rest as stored
  always_comb begin
    rd_word = mem[bus.addr];
    for (int i = 0; i < NB_COL; i++)
      if (WRITE_MODE == 1 && wr && bus.be[i]) rd_word[i*COL_WIDTH +: COL_WIDTH] = bus.din[i*COL_WIDTH +: COL_WIDTH];
  end
  // BRAM array with column writes and its registered read port
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB_COL; i++)
      if (wr_col[i]) mem[wr_addr][i*COL_WIDTH +: COL_WIDTH] <= wr_data[i*COL_WIDTH +: COL_WIDTH];
    if (reset) rd_q <= '0;
    else if (rd_en) rd_q <= rd_word;
  end
  // valid tracking and optional output stage; dout only moves when a result lands
  always_comb begin
    v1_d = rd_en;
    v2_d = v1_q;
    dout_d = v1_q ? rd_q : dout_q;
  end
  // pipeline flops, flushed by reset so in-flight reads never surface
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      dout_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      dout_q <= dout_d;
    end
  end
  assign bus.dout = OUT_REG != 0 ? dout_q : rd_q;
  assign bus.dout_valid = OUT_REG != 0 ? v2_q : v1_q;
endmodule

// File: tb/tb_xilinx_one_port_ram_pipe.sv
// tb_xilinx_one_port_ram_pipe: seven configurations driven by shared stimulus, each with its own reference model and scoreboard
module tb_xilinx_one_port_ram_pipe;
  localparam int AW = 4;
  localparam int CW = 8;
  localparam int NC = 2;
  localparam int NCFG = 7;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic we = 1'b0;
  logic [1:0] be = '0;
  logic [3:0] addr = '0;
  logic [15:0] din = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  task automatic step(input logic e, input logic w, input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    reset = 1'b0;
    en = e;
    we = w;
    be = b;
    addr = a;
    din = d;
  endtask

  task automatic rst(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      en = 1'b0;
    end
  endtask

  task automatic rnd(input int n, input bit allow_rst);
    repeat (n) begin
      if (allow_rst && $urandom_range(0, 63) == 0) rst(1 + $urandom_range(0, 2));
      else step($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int WM = g % 3;
    localparam int ORG = (g / 3) % 2;
    localparam int CLR = g < 6 ? 1 : 0;
    localparam int L = 1 + ORG;
    typedef struct {logic [15:0] d; logic [15:0] k; int due;} exp_t;
    xilinx_one_port_ram_pipe_if #(.ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC)) bus ();
    assign bus.en = en;
    assign bus.we = we;
    assign bus.be = be;
    assign bus.addr = addr;
    assign bus.din = din;
    xilinx_one_port_ram_pipe #(
      .ADDR_WIDTH(AW), .COL_WIDTH(CW), .NB_COL(NC),
      .WRITE_MODE(WM), .OUT_REG(ORG), .CLEAR_ON_RESET(CLR)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
    );
    exp_t q[$];
    logic [15:0] m [16];
    logic [15:0] mk [16];
    logic [15:0] held = '0;
    logic [15:0] held_k = '0;
    int cnt = 16;
    int lc = 0;
    bit seen = 0;
    initial for (int i = 0; i < 16; i++) begin
      m[i] = '0;
      mk[i] = '0;
    end
    // reference: words known column by column, accepted once the post-reset clear period is over
    always @(posedge clk) begin
      logic [15:0] bm, old, ok;
      lc++;
      if (reset) begin
        seen = 1;
        cnt = CLR != 0 ? 16 : 0;
        q.delete();
        held = '0;
        held_k = '1;
        if (CLR != 0) for (int i = 0; i < 16; i++) begin
          m[i] = '0;
          mk[i] = '1;
        end
      end else if (cnt > 0) cnt--;
      else if (en) begin
        bm = {{8{be[1]}}, {8{be[0]}}};
        old = m[addr];
        ok = mk[addr];
        if (we && be != 2'b00) begin
          m[addr] = (old & ~bm) | (din & bm);
          mk[addr] = ok | bm;
          if (WM == 0) q.push_back('{old, ok, lc + L - 1});
          else if (WM == 1) q.push_back('{m[addr], mk[addr], lc + L - 1});
        end else q.push_back('{old, ok, lc + L - 1});
      end
    end
    // monitor: ready timing, in-order results at latency L, dout holding between results
    always @(negedge clk) if (seen) begin
      exp_t e;
      checks++;
      if (bus.ready !== (!reset && cnt == 0)) begin
        errors++;
        $display("FAIL cfg%0d ready: got %b want %b (cycle %0d)", g, bus.ready, !reset && cnt == 0, lc);
      end
      checks++;
      if (bus.dout_valid === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL cfg%0d unexpected dout_valid: dout %h, want no result (cycle %0d)", g, bus.dout, lc);
        end else begin
          e = q.pop_front();
          if (e.due != lc || ((bus.dout ^ e.d) & e.k) != 0) begin
            errors++;
            $display("FAIL cfg%0d result: dout %h at cycle %0d, want %h (mask %h) at cycle %0d", g, bus.dout, lc, e.d, e.k, e.due);
          end
          held = e.d;
          held_k = e.k;
        end
      end else if (bus.dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL cfg%0d dout_valid unknown: got %b want 0/1", g, bus.dout_valid);
      end else if (q.size() > 0 && q[0].due <= lc) begin
        errors++;
        $display("FAIL cfg%0d missing result: dout_valid 0 at cycle %0d, want %h due %0d", g, lc, q[0].d, q[0].due);
        void'(q.pop_front());
      end else if (((bus.dout ^ held) & held_k) != 0) begin
        errors++;
        $display("FAIL cfg%0d dout hold: got %h want %h (cycle %0d)", g, bus.dout, held, lc);
      end
    end
  end

  initial begin
    rst(2);
    repeat (16) step(1'b1, 1'b1, 2'b11, 4'd9, 16'hBEEF);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 2'b11, 4'(a), 16'hFFFF);
    rst(2);
    repeat (16) step(1'b1, 1'b1, 2'b11, 4'd9, 16'hBEEF);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 2'b00, 4'(a), 16'h0);
    step(1'b1, 1'b1, 2'b11, 4'd3, 16'hABCD);
    step(1'b1, 1'b1, 2'b01, 4'd3, 16'h1234);
    step(1'b1, 1'b0, 2'b11, 4'd3, 16'h0);
    step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    step(1'b1, 1'b1, 2'b11, 4'd5, 16'h1111);
    step(1'b1, 1'b1, 2'b11, 4'd5, 16'h2222);
    step(1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 2'b11, 4'(a), 16'(a * 16'h0101 + 16'h1357));
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, 2'b00, 4'(a), 16'hDEAD);
    rnd(400, 1'b1);
    rst(1);
    rnd(7, 1'b0);
    rst(1);
    rnd(16, 1'b0);
    rnd(10, 1'b0);
    step(1'b1, 1'b0, 2'b11, 4'd2, 16'h0);
    rst(1);
    rnd(20, 1'b0);
    rnd(250, 1'b1);
    repeat (6) step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
